// File: rtl/key_entry_buffer_if.sv
// Keypad entry bus: keypad-side strobes in, buffered digits and status out.
interface key_entry_buffer_if;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key;
  logic       clear_buf;
  logic [3:0] key_ms_hr;
  logic [3:0] key_ls_hr;
  logic [3:0] key_ms_min;
  logic [3:0] key_ls_min;
  logic [2:0] entry_count;
  logic       entry_active;
  logic       entry_valid;
  logic       entry_timeout;

  // Keypad/control side
  modport master (
    output one_second, key_valid, key, clear_buf,
    input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
    input  entry_count, entry_active, entry_valid, entry_timeout
  );

  // Entry buffer side
  modport slave (
    input  one_second, key_valid, key, clear_buf,
    output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
    output entry_count, entry_active, entry_valid, entry_timeout
  );
endinterface

// File: rtl/key_entry_buffer.sv
// Keypad digit shift buffer with idle timeout and legal-HH:MM flag.
module key_entry_buffer #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic                clock,
  input  logic                reset,
  key_entry_buffer_if.slave   bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 6;
  localparam logic [CW-1:0] FULL = CW'(4);

  typedef enum logic {IDLE, ENTRY} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] ms_hr, ls_hr, ms_min, ls_min;
  logic [DW-1:0] ms_hr_nxt, ls_hr_nxt, ms_min_nxt, ls_min_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [IW-1:0] idle, idle_nxt;
  logic          active, active_nxt;
  logic          valid, valid_nxt;
  logic          timeout, timeout_nxt;

  logic digit_c;
  logic expire_c;

  assign digit_c  = bus.key_valid && (bus.key <= DW'(9));
  assign expire_c = (idle + IW'(1)) == IW'(TIMEOUT_SEC);

  // Legal 24h time check on the three constrained digits
  function automatic logic legal_time(input logic [DW-1:0] h1, input logic [DW-1:0] h0,
                                      input logic [DW-1:0] m1);
    logic hr_ok;
    hr_ok = (h1 == DW'(2)) ? (h0 <= DW'(3)) : (h0 <= DW'(9));
    return (h1 <= DW'(2)) && hr_ok && (m1 <= DW'(5));
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: clear_buf outranks digits, digits outrank ticks
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!bus.clear_buf && digit_c) state_nxt = ENTRY;
      end
      ENTRY: begin
        if (bus.clear_buf)                                 state_nxt = IDLE;
        else if (!digit_c && bus.one_second && expire_c)   state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the registered datapath and status outputs
  always_comb begin
    ms_hr_nxt   = ms_hr;
    ls_hr_nxt   = ls_hr;
    ms_min_nxt  = ms_min;
    ls_min_nxt  = ls_min;
    count_nxt   = count;
    idle_nxt    = idle;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    active_nxt  = (state_nxt == ENTRY);
    if (bus.clear_buf) begin
      ms_hr_nxt  = '0;
      ls_hr_nxt  = '0;
      ms_min_nxt = '0;
      ls_min_nxt = '0;
      count_nxt  = '0;
      idle_nxt   = '0;
      valid_nxt  = 1'b0;
    end else if (digit_c) begin
      ms_hr_nxt  = ls_hr;
      ls_hr_nxt  = ms_min;
      ms_min_nxt = ls_min;
      ls_min_nxt = bus.key;
      count_nxt  = (count >= FULL) ? FULL : count + CW'(1);
      idle_nxt   = '0;
      valid_nxt  = (count_nxt == FULL) && legal_time(ls_hr, ms_min, ls_min);
    end else if ((state == ENTRY) && bus.one_second) begin
      if (expire_c) begin
        ms_hr_nxt   = '0;
        ls_hr_nxt   = '0;
        ms_min_nxt  = '0;
        ls_min_nxt  = '0;
        count_nxt   = '0;
        idle_nxt    = '0;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b1;
      end else begin
        idle_nxt = idle + IW'(1);
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ms_hr   <= '0;
      ls_hr   <= '0;
      ms_min  <= '0;
      ls_min  <= '0;
      count   <= '0;
      idle    <= '0;
      active  <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      ms_hr   <= ms_hr_nxt;
      ls_hr   <= ls_hr_nxt;
      ms_min  <= ms_min_nxt;
      ls_min  <= ls_min_nxt;
      count   <= count_nxt;
      idle    <= idle_nxt;
      active  <= active_nxt;
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign bus.key_ms_hr     = ms_hr;
  assign bus.key_ls_hr     = ls_hr;
  assign bus.key_ms_min    = ms_min;
  assign bus.key_ls_min    = ls_min;
  assign bus.entry_count   = count;
  assign bus.entry_active  = active;
  assign bus.entry_valid   = valid;
  assign bus.entry_timeout = timeout;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Randomized + directed bench for key_entry_buffer against a queue-based model.
module tb_key_entry_buffer;

  localparam int unsigned T = 3;

  logic clock;
  logic reset;

  key_entry_buffer_if bus();

  key_entry_buffer #(.TIMEOUT_SEC(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: last up-to-4 digits, idle seconds, status flags
  int m_q[$];
  int m_idle    = 0;
  bit m_active  = 0;
  bit m_valid   = 0;
  bit m_timeout = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_legal();
    int hh;
    hh = m_q[0] * 10 + m_q[1];
    return (m_q.size() == 4) && (hh < 24) && (m_q[2] < 6);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_idle   = 0;
    m_active = 0;
    m_valid  = 0;
  endtask

  task automatic model_update(input bit rst, input bit ov, input bit kv, input int k, input bit cb);
    m_timeout = 0;
    if (rst || cb) begin
      model_clear();
    end else if (kv && k < 10) begin
      m_q.push_back(k);
      if (m_q.size() > 4) void'(m_q.pop_front());
      m_active = 1;
      m_idle   = 0;
      m_valid  = model_legal();
    end else if (ov && m_active) begin
      m_idle++;
      if (m_idle == int'(T)) begin
        model_clear();
        m_timeout = 1;
      end
    end
  endtask

  function automatic logic [15:0] model_buf();
    logic [15:0] e;
    e = '0;
    foreach (m_q[i]) e = {e[11:0], 4'(m_q[i])};
    return e;
  endfunction

  task automatic compare_all();
    check("buffer",  32'({bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min}),
          32'(model_buf()));
    check("count",   32'(bus.entry_count),   32'(m_q.size()));
    check("active",  32'(bus.entry_active),  32'(m_active));
    check("valid",   32'(bus.entry_valid),   32'(m_valid));
    check("timeout", 32'(bus.entry_timeout), 32'(m_timeout));
  endtask

  // Apply one cycle of inputs, advance model at the edge, compare after it
  task automatic step(input bit rst, input bit ov, input bit kv, input int k, input bit cb);
    reset          = rst;
    bus.one_second = ov;
    bus.key_valid  = kv;
    bus.key        = 4'(k);
    bus.clear_buf  = cb;
    @(posedge clock);
    model_update(rst, ov, kv, k, cb);
    #1;
    compare_all();
  endtask

  task automatic key(input int k);
    step(0, 0, 1, k, 0);
  endtask

  task automatic tick();
    step(0, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.one_second = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key        = 4'd0;
    bus.clear_buf  = 1'b0;
    #2;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // 12:30 is legal
    key(1); key(2); key(3); key(0);
    check("dir_1230_buf",   32'({bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min}), 32'h1230);
    check("dir_1230_valid", 32'(bus.entry_valid), 32'd1);

    // 25:00 illegal, window 50:09 illegal, 11:11 legal
    step(0, 0, 0, 0, 1);
    key(2); key(5); key(0); key(0);
    check("dir_2500_valid", 32'(bus.entry_valid), 32'd0);
    key(9);
    check("dir_5009_buf", 32'({bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min}), 32'h5009);
    key(1); key(1); key(1); key(1);
    check("dir_1111_valid", 32'(bus.entry_valid), 32'd1);

    // Non-digit code in IDLE and in ENTRY
    step(0, 0, 0, 0, 1);
    key(12);
    check("dir_nd_idle_active", 32'(bus.entry_active), 32'd0);
    key(6);
    key(12);
    check("dir_nd_entry_count", 32'(bus.entry_count), 32'd1);

    // Timeout after T ticks
    step(0, 0, 0, 0, 1);
    key(7); tick(); tick(); tick();
    check("dir_to_pulse", 32'(bus.entry_timeout), 32'd1);
    step(0, 0, 0, 0, 0);
    check("dir_to_one_cycle", 32'(bus.entry_timeout), 32'd0);

    // Digit coincident with a tick restarts the idle count
    key(4); tick(); tick();
    step(0, 1, 1, 5, 0);
    tick(); tick();
    check("dir_restart_no_to", 32'(bus.entry_timeout), 32'd0);
    tick();
    check("dir_restart_to", 32'(bus.entry_timeout), 32'd1);

    // clear_buf outranks a digit; reset mid-entry
    key(3); key(4);
    step(0, 0, 1, 8, 1);
    check("dir_clear_count", 32'(bus.entry_count), 32'd0);
    key(3); key(4);
    step(1, 0, 0, 0, 0);
    check("dir_reset_active", 32'(bus.entry_active), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit rst, ov, kv, cb;
      int k;
      rst = ($urandom_range(0, 199) == 0);
      cb  = ($urandom_range(0, 39) == 0);
      ov  = ($urandom_range(0, 9) < 3);
      kv  = ($urandom_range(0, 9) < 4);
      k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15))
                                        : int'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) k = int'($urandom_range(0, 2)) * ($urandom_range(0, 1) == 0 ? 1 : 0)
                                         + ($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(0, 5)));
      step(rst, ov, kv, k, cb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
